// File: rtl/harris_scan_if.sv
// Window-request and result-stream signals between the Harris scan controller
// and its window-assembly / result-consumer neighbours.
interface harris_scan_if #(
    parameter int XW = 9,
    parameter int YW = 8
);
    logic          win_req;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          win_ack;
    logic          is_corner;

    logic          res_valid;
    logic          res_ready;
    logic [XW-1:0] res_x;
    logic [YW-1:0] res_y;
    logic          res_corner;

    // Both channels are valid/ready: a transfer happens on a rising edge where
    // the initiator's request/valid and the responder's ack/ready are both high;
    // the initiator holds its payload stable until that edge.
    modport master (
        output win_req, win_x, win_y, res_valid, res_x, res_y, res_corner,
        input  win_ack, is_corner, res_ready
    );

    modport slave (
        input  win_req, win_x, win_y, res_valid, res_x, res_y, res_corner,
        output win_ack, is_corner, res_ready
    );
endinterface

// File: rtl/harris_scan_ctrl.sv
// Raster-order scan controller for the Harris corner detector over frame interiors.
// Optional macro HARRIS_CORNERS_ONLY_EN: only corner windows are emitted on the result stream.
module harris_scan_ctrl #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] corner_count,
    output logic [1:0]    dbg_state,
    harris_scan_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 2);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_req_q, win_req_d;
    logic          res_valid_q, res_valid_d;
    logic          done_q, done_d;
    logic [XW-1:0] res_x_q, res_x_d;
    logic [YW-1:0] res_y_q, res_y_d;
    logic          res_corner_q, res_corner_d;

    logic          at_last_x;
    logic          at_last;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          emit;

    always_comb begin
        at_last_x = (x_q == X_LAST);
        at_last   = at_last_x && (y_q == Y_LAST);
        next_x    = at_last_x ? XW'(1) : x_q + XW'(1);
        next_y    = at_last_x ? y_q + YW'(1) : y_q;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        win_req_d    = win_req_q;
        res_valid_d  = res_valid_q;
        done_d       = 1'b0;
        res_x_d      = res_x_q;
        res_y_d      = res_y_q;
        res_corner_d = res_corner_q;
        emit         = 1'b1;
`ifdef HARRIS_CORNERS_ONLY_EN
        emit         = bus.is_corner;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d       = XW'(1);
                    y_d       = YW'(1);
                    cnt_d     = '0;
                    win_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.win_ack) begin
                    if (emit) begin
                        res_x_d      = x_q;
                        res_y_d      = y_q;
                        res_corner_d = bus.is_corner;
                        if (bus.is_corner && cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                        win_req_d   = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else if (at_last) begin
                        // Suppressed final window: frame ends straight from REQ.
                        win_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        x_d = next_x;
                        y_d = next_y;
                    end
                end
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (at_last) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        x_d       = next_x;
                        y_d       = next_y;
                        win_req_d = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start in IDLE.
        if (abort) begin
            state_d      = S_IDLE;
            x_d          = x_q;
            y_d          = y_q;
            cnt_d        = cnt_q;
            win_req_d    = 1'b0;
            res_valid_d  = 1'b0;
            done_d       = 1'b0;
            res_x_d      = res_x_q;
            res_y_d      = res_y_q;
            res_corner_d = res_corner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            win_req_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            res_x_q      <= '0;
            res_y_q      <= '0;
            res_corner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            win_req_q    <= win_req_d;
            res_valid_q  <= res_valid_d;
            done_q       <= done_d;
            res_x_q      <= res_x_d;
            res_y_q      <= res_y_d;
            res_corner_q <= res_corner_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign corner_count   = cnt_q;
    assign dbg_state      = state_q;
    assign bus.win_req    = win_req_q;
    assign bus.win_x      = x_q;
    assign bus.win_y      = y_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_x      = res_x_q;
    assign bus.res_y      = res_y_q;
    assign bus.res_corner = res_corner_q;

endmodule
